// File: rtl/mem_block_responder_if.sv
// Bus between a block-read requester and mem_block_responder.
// MEM_BLOCK_WRITE_EN adds the write-back signals (reqWrite, wrData, wrTake).
interface mem_block_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] reqAddr;
  logic              ack;
  logic              busy;
  logic              dataValid;
  logic [DATA_W-1:0] dataOut;
  logic [1:0]        wordIdx;
  logic              done;
  logic [12:0]       readCount;
`ifdef MEM_BLOCK_WRITE_EN
  logic              reqWrite;
  logic [DATA_W-1:0] wrData;
  logic              wrTake;

  modport slave (
    input  req, reqAddr, reqWrite, wrData,
    output ack, busy, dataValid, dataOut, wordIdx, done, readCount, wrTake
  );
  modport master (
    output req, reqAddr, reqWrite, wrData,
    input  ack, busy, dataValid, dataOut, wordIdx, done, readCount, wrTake
  );
`else
  modport slave (
    input  req, reqAddr,
    output ack, busy, dataValid, dataOut, wordIdx, done, readCount
  );
  modport master (
    output req, reqAddr,
    input  ack, busy, dataValid, dataOut, wordIdx, done, readCount
  );
`endif
endinterface

// File: rtl/mem_block_responder.sv
// Block-transfer memory responder: accepts a 4-word block request, waits LATENCY cycles,
// then streams the block. Define MEM_BLOCK_WRITE_EN to compile in write-back bursts.
module mem_block_responder #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_block_responder_if.slave  bus,
  output logic [1:0]            dbg_state_o
);
  // Handshake: req is a level held by the requester until it sees the one-cycle
  // ack; beats are never stalled (no backpressure), one per cycle once BURST starts.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);
  localparam logic [12:0] CNT_MAX  = 13'h1FFF;

  state_e            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic [ADDR_W-3:0] blk_q, blk_d;
  logic [1:0]        idx_q, idx_d;
  logic [12:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.reqAddr[1:0];
  assign beat_addr        = {blk_q, idx_q};
  assign dbg_state_o      = state_q;

`ifdef MEM_BLOCK_WRITE_EN
  localparam int DEPTH = 1 << ADDR_W;

  logic              wr_q, wr_d;
  logic              beat_wr;
  // Words are stored XORed with their own address, so a zero power-up RAM reads
  // back as mem[i] = i without any initialisation pass.
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_word = mem_q[beat_addr] ^ DATA_W'(beat_addr);

  always_ff @(posedge clk) begin
    if (beat_wr && !rst) begin
      mem_q[beat_addr] <= bus.wrData ^ DATA_W'(beat_addr);
    end
  end
`else
  assign rd_word = DATA_W'(beat_addr);
`endif

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    blk_d         = blk_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    bus.ack       = 1'b0;
    bus.busy      = 1'b0;
    bus.dataValid = 1'b0;
    bus.dataOut   = '0;
    bus.wordIdx   = 2'd0;
    bus.done      = 1'b0;
    bus.readCount = cnt_q;
`ifdef MEM_BLOCK_WRITE_EN
    wr_d          = wr_q;
    beat_wr       = 1'b0;
    bus.wrTake    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_WAIT;
          lat_d   = LAT_INIT;
          blk_d   = bus.reqAddr[ADDR_W-1:2];
          idx_d   = 2'd0;
`ifdef MEM_BLOCK_WRITE_EN
          wr_d    = bus.reqWrite;
`endif
        end
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        // WAIT always opens with the counter at its load value, so that cycle is the ack cycle.
        bus.ack  = (lat_q == LAT_INIT);
        if (lat_q == 4'd0) begin
          state_d = S_BURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_BURST: begin
        bus.busy    = 1'b1;
        bus.wordIdx = idx_q;
        idx_d       = idx_q + 2'd1;
`ifdef MEM_BLOCK_WRITE_EN
        if (wr_q) begin
          beat_wr    = 1'b1;
          bus.wrTake = 1'b1;
        end else begin
          bus.dataValid = 1'b1;
          bus.dataOut   = rd_word;
        end
`else
        bus.dataValid = 1'b1;
        bus.dataOut   = rd_word;
`endif
        if (idx_q == 2'd3) begin
          bus.done = 1'b1;
          state_d  = S_IDLE;
`ifdef MEM_BLOCK_WRITE_EN
          if (!wr_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 13'd1;
`else
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 13'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lat_q   <= 4'd0;
      blk_q   <= '0;
      idx_q   <= 2'd0;
      cnt_q   <= 13'd0;
`ifdef MEM_BLOCK_WRITE_EN
      wr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef MEM_BLOCK_WRITE_EN
      wr_q    <= wr_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder (LATENCY 3); write-back checks compile in
// with MEM_BLOCK_WRITE_EN.
module tb_mem_block_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  logic       tb_take;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_count = 0;

  mem_block_responder_if #(.ADDR_W(15), .DATA_W(32)) bus();

  mem_block_responder #(.ADDR_W(15), .DATA_W(32), .LATENCY(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef MEM_BLOCK_WRITE_EN
  assign tb_take = bus.wrTake;
`else
  assign tb_take = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic r, input logic [14:0] a, input logic w);
    bus.req     = r;
    bus.reqAddr = a;
`ifdef MEM_BLOCK_WRITE_EN
    bus.reqWrite = w;
    bus.wrData   = 32'd0;
`else
    if (w) $display("write request ignored in read-only build");
`endif
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts falling edges from the current one until ack is seen; -1 on timeout.
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ack && lat < 20);
    if (!bus.ack) lat = -1;
  endtask

  // Called on the ack cycle; checks latency, the four beats and the idle cycle after done.
  task automatic collect_burst(input string tag, input logic [31:0] first_word, input bit is_write);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(bus.dataValid || tb_take) && w < 20);
    check_eq({tag, "_first_beat_lat"}, w, 3);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      check_eq({tag, "_idx"}, bus.wordIdx, i);
      check_eq({tag, "_busy"}, bus.busy, 1);
      check_eq({tag, "_done"}, bus.done, (i == 3));
      check_eq({tag, "_ack_low"}, bus.ack, 0);
      if (is_write) begin
        check_eq({tag, "_wr_take"}, tb_take, 1);
        check_eq({tag, "_wr_valid_low"}, bus.dataValid, 0);
        check_eq({tag, "_wr_data_zero"}, bus.dataOut, 0);
`ifdef MEM_BLOCK_WRITE_EN
        bus.wrData = first_word + i;
`endif
      end else begin
        check_eq({tag, "_valid"}, bus.dataValid, 1);
        check_eq({tag, "_data"}, bus.dataOut, first_word + i);
      end
    end
    if (!is_write) exp_count = (exp_count == 8191) ? 8191 : exp_count + 1;
    @(negedge clk);
    check_eq({tag, "_busy_after"}, bus.busy, 0);
    check_eq({tag, "_valid_after"}, bus.dataValid, 0);
    check_eq({tag, "_count"}, bus.readCount, exp_count);
  endtask

  task automatic do_read(input string tag, input logic [14:0] addr, input logic [31:0] first_word);
    int lat;
    drive_req(1'b1, addr, 1'b0);
    wait_ack(lat);
    check_eq({tag, "_ack_lat"}, lat, 1);
    check_eq({tag, "_ack_busy"}, bus.busy, 1);
    drive_req(1'b0, 15'd0, 1'b0);
    collect_burst(tag, first_word, 1'b0);
  endtask

  initial begin
    int lat;
    int w;
    drive_req(1'b0, 15'd0, 1'b0);

    apply_reset(2);
    check_eq("rst_ack", bus.ack, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_valid", bus.dataValid, 0);
    check_eq("rst_data", bus.dataOut, 0);
    check_eq("rst_idx", bus.wordIdx, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_count", bus.readCount, 0);
    check_eq("rst_state", dbg_state, 0);

    do_read("rd0406", 15'h0406, 32'h404);
    do_read("rd7fff", 15'h7FFF, 32'h7FFC);

    // req held high across two blocks: next ack lands two cycles after done
    drive_req(1'b1, 15'h0012, 1'b0);
    wait_ack(lat);
    check_eq("b2b_ack_lat", lat, 1);
    collect_burst("b2b_a", 32'h10, 1'b0);
    wait_ack(lat);
    check_eq("b2b_gap", lat + 1, 2);
    collect_burst("b2b_b", 32'h10, 1'b0);
    drive_req(1'b0, 15'd0, 1'b0);

    // reset on the second beat, with req raised alongside rst
    drive_req(1'b1, 15'h0404, 1'b0);
    wait_ack(lat);
    drive_req(1'b0, 15'd0, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.dataValid && w < 20);
    @(negedge clk);
    check_eq("mid_second_beat", bus.wordIdx, 1);
    rst = 1'b1;
    drive_req(1'b1, 15'h0404, 1'b0);
    @(negedge clk);
    check_eq("mid_rst_ack", bus.ack, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_valid", bus.dataValid, 0);
    check_eq("mid_rst_data", bus.dataOut, 0);
    check_eq("mid_rst_idx", bus.wordIdx, 0);
    check_eq("mid_rst_done", bus.done, 0);
    check_eq("mid_rst_count", bus.readCount, 0);
    exp_count = 0;
    @(negedge clk);
    check_eq("rst_req_ignored", bus.ack, 0);
    rst = 1'b0;
    wait_ack(lat);
    check_eq("post_rst_ack_seen", (lat >= 1 && lat <= 2), 1);
    drive_req(1'b0, 15'd0, 1'b0);
    collect_burst("post_rst", 32'h404, 1'b0);

    // continuous requests until the counter saturates
    drive_req(1'b1, 15'h0020, 1'b0);
    for (int b = 1; b <= 8192; b++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.done && w < 20);
      if (!bus.done) begin
        check_eq("sat_done_timeout", 0, 1);
        break;
      end
      check_eq("sat_last_data", bus.dataOut, 32'h23);
      exp_count = (exp_count == 8191) ? 8191 : exp_count + 1;
      if (b == 8190 || b == 8192) begin
        @(negedge clk);
        check_eq("sat_count", bus.readCount, exp_count);
        if (b == 8192) drive_req(1'b0, 15'd0, 1'b0);
      end
    end
    check_eq("sat_model", exp_count, 8191);
    @(negedge clk);
    check_eq("sat_hold", bus.readCount, 13'd8191);
    repeat (4) @(negedge clk);
    check_eq("sat_idle", bus.busy, 0);

`ifdef MEM_BLOCK_WRITE_EN
    apply_reset(2);
    exp_count = 0;
    drive_req(1'b1, 15'h0100, 1'b1);
    wait_ack(lat);
    check_eq("wr_ack_lat", lat, 1);
    drive_req(1'b0, 15'd0, 1'b0);
    collect_burst("wr0100", 32'hA0, 1'b1);
    do_read("rdback", 15'h0100, 32'hA0);
    do_read("rd_untouched", 15'h0104, 32'h104);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of main memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LATENCY, default 3, cycles from ack to first data word; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  block-transfer request; requester holds high until ack seen.
REQ-007 reqAddr  input  ADDR_W  word address; low 2 bits ignored (block = 4 words).
REQ-008 ack  output  1  one-cycle pulse: request accepted, address captured.
REQ-009 busy  output  1  high from ack cycle through done cycle inclusive.
REQ-010 dataValid  output  1  high on each cycle carrying a read word.
REQ-011 dataOut  output  DATA_W  read word; 0 whenever dataValid low.
REQ-012 wordIdx  output  2  word offset within block of current burst beat.
REQ-013 done  output  1  one-cycle pulse coincident with final (4th) beat.
REQ-014 readCount  output  13  completed read-block counter, saturating.

Function
REQ-015 Storage: 2^ADDR_W words; word i power-up contents = i zero-extended; reset does not alter contents.
REQ-016 States: IDLE, WAIT, BURST.
REQ-017 IDLE: req sampled high at edge N -> cycle N+1: ack=1, busy=1, base={reqAddr[ADDR_W-1:2],2'b00}, latency counter=LATENCY-1, state WAIT.
REQ-018 req while not IDLE is ignored; no queuing; requester must keep req high until ack.
REQ-019 WAIT: counter decrements each cycle; at 0 -> BURST next cycle; first beat at cycle N+1+LATENCY.
REQ-020 BURST: 4 consecutive beats, wordIdx 0,1,2,3, dataOut=mem[base+wordIdx], no gaps, no backpressure.
REQ-021 Beat 3: done=1, readCount+1 (holds at 8191), -> IDLE next cycle.
REQ-022 Back-to-back: req high during done cycle is not accepted; earliest next ack is 2 cycles after done.
REQ-023 Address never wraps within block (base aligned); max block base = 2^ADDR_W-4.
REQ-024 ack, done are single-cycle pulses; never high in same cycle.

Reset
REQ-025 rst high at any edge, including mid-WAIT/BURST: state IDLE, ack=busy=dataValid=done=0, dataOut=0, wordIdx=0, readCount=0; burst in progress is abandoned.
REQ-026 req high concurrently with rst is ignored; earliest ack is 2 cycles after rst deasserts with req held high.

Configuration
REQ-027 Macro MEM_BLOCK_WRITE_EN compiles in write-back support.
REQ-028 With it: extra ports reqWrite input 1, wrData input DATA_W, wrTake output 1; reqWrite captured with reqAddr at accept.
REQ-029 With it, write request: same IDLE/WAIT/BURST timing; each BURST beat writes wrData into mem[base+wordIdx], wrTake=1, dataValid=0, dataOut=0; done pulses on beat 3; readCount unchanged.
REQ-030 Without it: ports absent, every request is a read.

Verification
REQ-031 rst 2 cycles, req=1 reqAddr=0x0406 -> ack 1 cycle after sample, dataValid 3 cycles after ack, dataOut 0x404..0x407, done on 0x407, readCount=1.
REQ-032 req held high continuously from reset release -> acks exactly 2 cycles after each done, readCount increments per block.
REQ-033 rst asserted on second BURST beat -> next cycle all outputs 0, readCount=0; fresh request to 0x0404 returns 0x404..0x407.
REQ-034 reqAddr=0x7FFF -> beats 0x7FFC..0x7FFF, no wrap to 0.
REQ-035 8192 read blocks -> readCount reaches 8191 and stays 8191 (no wrap to 0).
REQ-036 MEM_BLOCK_WRITE_EN: write 0xA0..0xA3 to block 0x0100, then read 0x0100 -> wrTake on 4 beats, readback 0xA0..0xA3, readCount=1.
